// File: rtl/selector_tiempo.sv
// Front-panel heating time selector: debounced up/down/clear buttons with
// press-and-hold auto-repeat, saturating 0..MAX_VAL, frozen while bloqueo is high.
module selector_tiempo #(
    parameter int TICK_DIV     = 250000,
    parameter int MAX_VAL      = 31,
    parameter int HOLD_TICKS   = 200,
    parameter int REPEAT_TICKS = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clear,
    input  logic       bloqueo,
    output logic [4:0] numero,
    output logic       cambio,
    output logic       en_limite
);

    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int CW   = (HMAX > 1) ? $clog2(HMAX + 1) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HOLD_UP = 3'd1;
    localparam logic [2:0] HOLD_DN = 3'd2;
    localparam logic [2:0] RPT_UP  = 3'd3;
    localparam logic [2:0] RPT_DN  = 3'd4;

    logic [TW-1:0] tick_cnt_r;
    logic          tick_s;
    // Bit order in the sample vectors: {clear, down, up}.
    logic [2:0]    s0_r, s1_r, s2_r;
    logic [2:0]    lvl_s, press_s;
    logic [2:0]    state_r, state_nx_s;
    logic [CW-1:0] hcnt_r, hcnt_nx_s;
    logic          step_up_s, step_dn_s, clr_s;
    logic [4:0]    numero_r, numero_nx_s;
    logic          cambio_r;

    assign tick_s    = (tick_cnt_r == TW'(TICK_DIV - 1));
    assign lvl_s     = s1_r & s2_r;
    assign press_s   = s1_r & ~s2_r & {3{tick_s}};
    assign numero    = numero_r;
    assign cambio    = cambio_r;
    assign en_limite = (numero_r == 5'd0) || (numero_r == 5'(MAX_VAL));

    // Sample-tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Debounce shift registers, advanced only on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_r <= 3'b000;
            s1_r <= 3'b000;
            s2_r <= 3'b000;
        end else if (tick_s) begin
            s0_r <= {btn_clear, btn_down, btn_up};
            s1_r <= s0_r;
            s2_r <= s1_r;
        end else begin
            s0_r <= s0_r;
            s1_r <= s1_r;
            s2_r <= s2_r;
        end
    end

    // Hold/auto-repeat FSM next state and step requests.
    always_comb begin
        state_nx_s = state_r;
        hcnt_nx_s  = hcnt_r;
        step_up_s  = 1'b0;
        step_dn_s  = 1'b0;
        clr_s      = 1'b0;
        if (bloqueo) begin
            state_nx_s = IDLE;
            hcnt_nx_s  = '0;
        end else if (tick_s) begin
            if (press_s[2]) begin
                clr_s      = 1'b1;
                state_nx_s = IDLE;
                hcnt_nx_s  = '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        hcnt_nx_s = '0;
                        if (press_s[0] && !press_s[1] && !lvl_s[1]) begin
                            step_up_s  = 1'b1;
                            state_nx_s = HOLD_UP;
                        end else if (press_s[1] && !press_s[0] && !lvl_s[0]) begin
                            step_dn_s  = 1'b1;
                            state_nx_s = HOLD_DN;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end
                    HOLD_UP, RPT_UP: begin
                        if (!lvl_s[0] || lvl_s[1]) begin
                            state_nx_s = IDLE;
                            hcnt_nx_s  = '0;
                        end else if ((state_r == HOLD_UP && hcnt_r == CW'(HOLD_TICKS - 1)) ||
                                     (state_r == RPT_UP  && hcnt_r == CW'(REPEAT_TICKS - 1))) begin
                            step_up_s  = 1'b1;
                            state_nx_s = RPT_UP;
                            hcnt_nx_s  = '0;
                        end else begin
                            hcnt_nx_s = hcnt_r + CW'(1);
                        end
                    end
                    HOLD_DN, RPT_DN: begin
                        if (!lvl_s[1] || lvl_s[0]) begin
                            state_nx_s = IDLE;
                            hcnt_nx_s  = '0;
                        end else if ((state_r == HOLD_DN && hcnt_r == CW'(HOLD_TICKS - 1)) ||
                                     (state_r == RPT_DN  && hcnt_r == CW'(REPEAT_TICKS - 1))) begin
                            step_dn_s  = 1'b1;
                            state_nx_s = RPT_DN;
                            hcnt_nx_s  = '0;
                        end else begin
                            hcnt_nx_s = hcnt_r + CW'(1);
                        end
                    end
                    default: begin
                        state_nx_s = IDLE;
                        hcnt_nx_s  = '0;
                    end
                endcase
            end
        end else begin
            state_nx_s = state_r;
        end
    end

    // Saturating value update; a no-op step leaves the value untouched.
    always_comb begin
        numero_nx_s = numero_r;
        if (clr_s) begin
            numero_nx_s = 5'd0;
        end else if (step_up_s && numero_r < 5'(MAX_VAL)) begin
            numero_nx_s = numero_r + 5'd1;
        end else if (step_dn_s && numero_r != 5'd0) begin
            numero_nx_s = numero_r - 5'd1;
        end else begin
            numero_nx_s = numero_r;
        end
    end

    // State, hold counter, value and change pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            hcnt_r   <= '0;
            numero_r <= 5'd0;
            cambio_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            hcnt_r   <= hcnt_nx_s;
            numero_r <= numero_nx_s;
            cambio_r <= (numero_nx_s != numero_r);
        end
    end

endmodule

// File: tb/tb_selector_tiempo.sv
// Randomized and directed bench for selector_tiempo against a tick-level
// behavioural model of the button/hold/repeat rules.
module tb_selector_tiempo;

    localparam int TD   = 4;
    localparam int MAXV = 31;
    localparam int HT   = 3;
    localparam int RT   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up = 1'b0, dn = 1'b0, clr = 1'b0, bloq = 1'b0;
    logic [4:0] numero;
    logic       cambio, en_limite;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulses = 0;

    // Reference model state.
    int m_val, m_dir, m_age, m_tcnt;
    bit m_cambio;
    bit hq[3][$];

    selector_tiempo #(
        .TICK_DIV(TD), .MAX_VAL(MAXV), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(up), .btn_down(dn), .btn_clear(clr),
        .bloqueo(bloq), .numero(numero), .cambio(cambio), .en_limite(en_limite)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_dir = 0; m_age = 0; m_tcnt = 0; m_cambio = 0;
        for (int b = 0; b < 3; b++) hq[b] = '{0, 0, 0};
    endtask

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > MAXV) return MAXV;
        return v;
    endfunction

    // One clock of the reference: rules are evaluated per tick from sample history.
    task automatic model_cycle();
        int  prev;
        bit  tick;
        bit  lv[3], pr[3];
        bit  raw[3];
        int  own, oth;
        prev = m_val;
        tick = (m_tcnt == TD - 1);
        m_tcnt = tick ? 0 : m_tcnt + 1;
        if (bloq) m_dir = 0;
        if (tick) begin
            raw = '{up, dn, clr};
            for (int b = 0; b < 3; b++) begin
                lv[b] = hq[b][1] && hq[b][2];
                pr[b] = hq[b][1] && !hq[b][2];
            end
            if (!bloq) begin
                if (pr[2]) begin
                    m_val = 0; m_dir = 0;
                end else if (m_dir == 0) begin
                    if (pr[0] && !pr[1] && !lv[1]) begin
                        m_dir = 1; m_age = 0; m_val = sat(m_val + 1);
                    end else if (pr[1] && !pr[0] && !lv[0]) begin
                        m_dir = -1; m_age = 0; m_val = sat(m_val - 1);
                    end
                end else begin
                    own = (m_dir > 0) ? 0 : 1;
                    oth = 1 - own;
                    if (!lv[own] || lv[oth]) begin
                        m_dir = 0;
                    end else begin
                        m_age++;
                        if (m_age == HT || (m_age > HT && (m_age - HT) % RT == 0))
                            m_val = sat(m_val + m_dir);
                    end
                end
            end
            for (int b = 0; b < 3; b++) begin
                hq[b].push_front(raw[b]);
                void'(hq[b].pop_back());
            end
        end
        m_cambio = (m_val != prev);
    endtask

    task automatic step_cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_cycle();
        #1;
        check_val("numero", numero, m_val);
        check_val("cambio", cambio, m_cambio);
        check_val("en_limite", en_limite, (m_val == 0 || m_val == MAXV));
        if (cambio) n_pulses++;
    endtask

    task automatic run_ticks(input int n);
        repeat (n * TD) step_cycle();
    endtask

    task automatic pulse(input logic u, input logic d, input logic c, input int on_t, input int off_t);
        up = u; dn = d; clr = c;
        run_ticks(on_t);
        up = 1'b0; dn = 1'b0; clr = 1'b0;
        run_ticks(off_t);
    endtask

    initial begin
        int p0;
        int guard;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check_val("reset_numero", numero, 0);
        check_val("reset_cambio", cambio, 0);
        check_val("reset_en_limite", en_limite, 1);
        step_cycle();
        step_cycle();
        rst = 1'b0;

        // 1: five short presses
        p0 = n_pulses;
        repeat (5) pulse(1'b1, 1'b0, 1'b0, 3, 3);
        check_val("t1_numero", numero, 5);
        check_val("t1_pulses", n_pulses - p0, 5);
        check_val("t1_limite", en_limite, 0);

        // 2: long hold saturates at MAX_VAL
        up = 1'b1;
        run_ticks(80);
        p0 = n_pulses;
        run_ticks(10);
        check_val("t2_numero", numero, 31);
        check_val("t2_limite", en_limite, 1);
        check_val("t2_no_cambio", n_pulses - p0, 0);
        up = 1'b0;
        run_ticks(5);

        // 3: down at zero, clear while up held
        pulse(1'b0, 1'b0, 1'b1, 3, 3);
        check_val("t3_clear", numero, 0);
        p0 = n_pulses;
        pulse(1'b0, 1'b1, 1'b0, 3, 3);
        check_val("t3_down_at_0", numero, 0);
        check_val("t3_down_no_cambio", n_pulses - p0, 0);
        repeat (12) pulse(1'b1, 1'b0, 1'b0, 3, 3);
        check_val("t3_twelve", numero, 12);
        up = 1'b1; clr = 1'b1;
        run_ticks(4);
        clr = 1'b0;
        run_ticks(10);
        check_val("t3_clear_held_up", numero, 0);
        up = 1'b0;
        run_ticks(4);

        // 4: up and down pressed together
        repeat (7) pulse(1'b1, 1'b0, 1'b0, 3, 3);
        p0 = n_pulses;
        pulse(1'b1, 1'b1, 1'b0, 6, 4);
        check_val("t4_both", numero, 7);
        check_val("t4_no_cambio", n_pulses - p0, 0);

        // 5: bloqueo freezes value; held button needs a re-press afterwards
        repeat (3) pulse(1'b1, 1'b0, 1'b0, 3, 3);
        bloq = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 3, 3);
        pulse(1'b0, 1'b1, 1'b0, 3, 3);
        pulse(1'b0, 1'b0, 1'b1, 3, 3);
        check_val("t5_frozen", numero, 10);
        up = 1'b1;
        run_ticks(5);
        bloq = 1'b0;
        run_ticks(10);
        check_val("t5_held_no_step", numero, 10);
        up = 1'b0;
        run_ticks(4);
        pulse(1'b1, 1'b0, 1'b0, 3, 3);
        check_val("t5_repress", numero, 11);

        // 6: async reset during auto-repeat at 20
        up = 1'b1;
        guard = 0;
        while (m_val != 20 && guard < 400) begin
            step_cycle();
            guard++;
        end
        check_val("t6_reach20_timeout", (guard < 400), 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_val("t6_async_numero", numero, 0);
        check_val("t6_async_cambio", cambio, 0);
        up = 1'b0;
        step_cycle();
        step_cycle();
        rst = 1'b0;
        run_ticks(12);
        check_val("t6_no_step", numero, 0);
        pulse(1'b1, 1'b0, 1'b0, 3, 3);
        check_val("t6_fresh_press", numero, 1);

        // Random phase
        for (int i = 0; i < 120; i++) begin
            up   = ($urandom_range(0, 99) < 45);
            dn   = ($urandom_range(0, 99) < 30);
            clr  = ($urandom_range(0, 99) < 8);
            bloq = ($urandom_range(0, 99) < 12);
            run_ticks($urandom_range(1, 12));
        end
        up = 1'b0; dn = 1'b0; clr = 1'b0; bloq = 1'b0;
        run_ticks(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
